mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port data memory between the processor core (port 0) and the program loader/debug port (port 1). Each port gets a request/grant interface. Port 1 is how programs and data are placed in memory while the core runs or is held. Arbitration is round-robin, with an optional lock so one port can own the memory for multi-word sequences (read-modify-write, program load bursts). The block sits between the requesters and the memory, and drives the memory's enable, write-enable, address and write-data lines.

## Interface
- width, 32, data bus width
- addrsize, 8, address bus width
- clk  in  1  rising-edge clock
- nrst  in  1  synchronous active-low reset
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership after this grant
- addr0 / addr1  in  addrsize  access address
- wdata0 / wdata1  in  width  write data
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for that port
- rdata  out  width  read data, shared by both ports, qualified by rvalidN
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  addrsize  memory address
- mem_wdata  out  width  memory write data
- mem_rdata  in  width  memory read data, valid one cycle after a read strobe

## Operation
- At most one grant per cycle; gnt0 & gnt1 is never 1.
- The granted port's we/addr/wdata drive mem_we/mem_addr/mem_wdata in the same cycle, and mem_en = 1.
- When nothing is granted: mem_en = 0, mem_we = 0, mem_addr and mem_wdata = 0.
- Round-robin:
  - Register `last` holds the index of the last granted port.
  - With both requests active and state IDLE, the port ≠ `last` wins.
  - A single requester always wins.
  - `last` updates on every grant.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE → LOCKp: port p granted with lockp = 1.
  - LOCKp: only port p may be granted; the other port's req is held off with gnt = 0.
  - LOCKp → IDLE: at the end of any cycle with lockp = 0, whether or not reqp is active.
  - The release cycle still grants port p if it requests.
- Read tracking:
  - On a granted read, a registered pending flag and owner index are set.
  - Next cycle: rdata = mem_rdata, and rvalid of the owner = 1 for exactly one cycle.
  - Back-to-back reads, including reads alternating between ports, are fully pipelined at one per cycle.
- Writes produce no rvalid.
- A read and a write to the same address in consecutive cycles are serialized in grant order; the memory itself decides the data returned.

## Timing
- Reset values:
  - gnt0/1 = 0, rvalid0/1 = 0, rdata = 0
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - state = IDLE, `last` = 1, so port 0 wins the first tie
  - pending = 0
- Grant latency is 0 cycles: gnt is valid in the cycle req is high.
- Read latency is 1 cycle from grant to rvalid.
- A requester holds req/we/addr/wdata stable until it sees gnt; it may change them the cycle after.
- While nrst = 0, gnt and mem_en are forced low regardless of req.
- Reset mid-read: the pending response is dropped, and no rvalid follows the reset cycle.
- Lock asserted by a port that is not granted in that cycle has no effect.
- Both lock inputs high in IDLE with both requesting: the round-robin winner takes the lock.

## Structure
- Package mem_arb_pkg:
  - state enum arb_state_t {IDLE, LOCK0, LOCK1}
  - port index constants PORT_CORE = 0, PORT_LOAD = 1
- One sub-module, mem_arb_rr: combinational 2-way round-robin pick.
  - Inputs: req vector, `last`, lock-state mask.
  - Output: one-hot grant.
  - Reusable when more ports are added.
- The top level holds the FSM, the `last`/pending/owner registers, the memory-side mux and the rdata register.

## Test plan
- Reset: hold nrst = 0 for 3 cycles with req0 = req1 = 1 → gnt0 = gnt1 = 0, mem_en = 0, all outputs 0.
- Tie-break: after reset, both ports read, req0 addr 0x10 and req1 addr 0x20, for 4 cycles.
  - Grants go 0,1,0,1.
  - rvalid0/rvalid1 alternate one cycle later.
  - rdata = MEM[0x10] then MEM[0x20].
- Lock: port 1 writes 0xA5 to 0x05 with lock1 = 1 for 3 cycles while req0 = 1.
  - gnt0 stays 0 throughout.
  - Port 0 is granted the cycle after lock1 drops.
- Pipelined reads: port 0 reads 0x00..0x03 back-to-back → rvalid0 high for 4 consecutive cycles with the matching data, mem_en high for 4 cycles.
- Write then read: port 0 writes 0xDEADBEEF to 0x7F, then reads 0x7F → rvalid0 with rdata = 0xDEADBEEF; no rvalid on the write.
- Reset mid-read: grant a port 1 read, assert nrst = 0 the next cycle → rvalid1 never pulses; state returns to IDLE, and port 0 wins the next tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: none (types only).
// Backpressure: none (types only).
package mem_arb_pkg;

  // Arbiter ownership state: open round-robin, or held by one port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int   NPORTS    = 2;
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  // Ports allowed to compete in a given state (bit p = port p eligible).
  function automatic logic [NPORTS-1:0] state_mask(input arb_state_t s);
    logic [NPORTS-1:0] m;
    case (s)
      LOCK0:   m = 2'b01;
      LOCK1:   m = 2'b10;
      default: m = 2'b11;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin pick over the eligible requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: masked-off or losing requesters simply see no grant bit.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              last,
  input  logic [NPORTS-1:0] mask,
  output logic [NPORTS-1:0] gnt
);

  logic [NPORTS-1:0] elig;

  // On a tie the port that was not granted last wins; otherwise the lone eligible requester wins.
  always_comb begin
    elig = req & mask;
    gnt  = '0;
    if (elig == 2'b11) begin
      gnt = (last == PORT_LOAD) ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between the core (port 0) and the loader/debug port (port 1).
// Latency: grant and memory strobe in the request cycle; read data and rvalid one cycle after grant.
// Backpressure: a losing or locked-out port sees gnt = 0 and must hold its request until granted.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int width    = 32,
  parameter int addrsize = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic [addrsize-1:0] addr0,
  input  logic [addrsize-1:0] addr1,
  input  logic [width-1:0]    wdata0,
  input  logic [width-1:0]    wdata1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [width-1:0]    rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [addrsize-1:0] mem_addr,
  output logic [width-1:0]    mem_wdata,
  input  logic [width-1:0]    mem_rdata
);

  arb_state_t        state;
  logic              last;
  logic              pending;
  logic              owner;
  logic [width-1:0]  rdata_q;

  logic [NPORTS-1:0] req_vec;
  logic [NPORTS-1:0] elig_mask;
  logic [NPORTS-1:0] rr_gnt;
  logic [NPORTS-1:0] gnt;
  logic              granted;
  logic              gnt_port;
  logic              gnt_read;

  assign req_vec   = {req1, req0};
  assign elig_mask = state_mask(state);

  mem_arb_rr u_rr (
    .req  (req_vec),
    .last (last),
    .mask (elig_mask),
    .gnt  (rr_gnt)
  );

  // Reset overrides any request so nothing reaches the memory while nrst is low.
  assign gnt      = nrst ? rr_gnt : '0;
  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign granted  = |gnt;
  assign gnt_port = gnt[1];
  assign gnt_read = granted & ~mem_we;

  // Memory-side mux: the granted port drives the bus, an idle cycle drives all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Ownership FSM: a grant with lock held enters LOCKp; any cycle with lockp low returns to IDLE.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (gnt[0] && lock0) begin
            state <= LOCK0;
          end else if (gnt[1] && lock1) begin
            state <= LOCK1;
          end
        end
        LOCK0: begin
          if (!lock0) state <= IDLE;
        end
        LOCK1: begin
          if (!lock1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Remember the most recent winner; starts at port 1 so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      last <= PORT_LOAD;
    end else if (granted) begin
      last <= gnt_port;
    end
  end

  // Track the read issued this cycle so its data can be steered to the right port next cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pending <= 1'b0;
      owner   <= PORT_CORE;
    end else begin
      pending <= gnt_read;
      if (gnt_read) owner <= gnt_port;
    end
  end

  // Hold the last returned word so rdata stays stable between responses.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rdata_q <= '0;
    end else if (pending) begin
      rdata_q <= mem_rdata;
    end
  end

  // A response in flight when reset arrives is dropped, so the reset cycle shows no rvalid.
  assign rdata   = !nrst ? '0 : (pending ? mem_rdata : rdata_q);
  assign rvalid0 = nrst & pending & (owner == PORT_CORE);
  assign rvalid1 = nrst & pending & (owner == PORT_LOAD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written lock/release sequence.
// Latency: checks grants and bus in the request cycle, read responses one cycle later via a scoreboard.
// Backpressure: stimulus holds a losing request until the expected grant, as a real requester would.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int AW = 8;

  typedef struct {
    logic          nrst;
    logic          r0, w0, l0;
    logic [AW-1:0] a0;
    logic [W-1:0]  d0;
    logic          r1, w1, l1;
    logic [AW-1:0] a1;
    logic [W-1:0]  d1;
    logic          g0, g1;
  } vec_t;

  typedef struct packed {
    logic         port;
    logic [W-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0]  rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_load;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem    [0:255];
  logic [W-1:0] shadow [0:255];
  exp_t         sb[$];
  vec_t         vecs[$];

  always #5 clk = ~clk;

  mem_arbiter #(.width(W), .addrsize(AW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .lock0     (lock0),
    .lock1     (lock1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [W-1:0] init_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous single-port memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i[7:0]);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  function automatic vec_t mk(input int n,
                              input int r0, input int w0, input int l0,
                              input logic [AW-1:0] a0, input logic [W-1:0] d0,
                              input int r1, input int w1, input int l1,
                              input logic [AW-1:0] a1, input logic [W-1:0] d1,
                              input int g0, input int g1);
    vec_t v;
    v.nrst = n[0];
    v.r0 = r0[0]; v.w0 = w0[0]; v.l0 = l0[0]; v.a0 = a0; v.d0 = d0;
    v.r1 = r1[0]; v.w1 = w1[0]; v.l1 = l1[0]; v.a1 = a1; v.d1 = d1;
    v.g0 = g0[0]; v.g1 = g1[0];
    return v;
  endfunction

  task automatic step(input vec_t v, input int idx);
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [W-1:0]  e_wdata;
    exp_t          e;
    @(posedge clk);
    #1;
    nrst = v.nrst;
    req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
    @(negedge clk);

    // Responses expected this cycle were pushed last cycle; reset drops them.
    if (!v.nrst) sb.delete();
    if (sb.size() > 0 || rvalid0 || rvalid1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_spurious step %0d: rvalid0=%0b rvalid1=%0b, want none", idx, rvalid0, rvalid1);
      end else begin
        e = sb.pop_front();
        if (rvalid0 !== !e.port || rvalid1 !== e.port || rdata !== e.data) begin
          errors++;
          $display("FAIL read_resp step %0d: rvalid0=%0b rvalid1=%0b rdata=%h, want port %0d data %h",
                   idx, rvalid0, rvalid1, rdata, e.port, e.data);
        end
      end
    end

    checks++;
    if (gnt0 !== v.g0 || gnt1 !== v.g1) begin
      errors++;
      $display("FAIL grant step %0d: gnt0=%0b gnt1=%0b, want %0b %0b", idx, gnt0, gnt1, v.g0, v.g1);
    end

    e_en = v.g0 | v.g1;
    e_we = v.g0 ? v.w0 : (v.g1 ? v.w1 : 1'b0);
    e_addr = v.g0 ? v.a0 : (v.g1 ? v.a1 : '0);
    e_wdata = v.g0 ? v.d0 : (v.g1 ? v.d1 : '0);
    checks++;
    if (mem_en !== e_en || mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
      errors++;
      $display("FAIL mem_bus step %0d: en=%0b we=%0b addr=%h wdata=%h, want %0b %0b %h %h",
               idx, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
    end

    if (!v.nrst) begin
      checks++;
      if (rdata !== '0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs step %0d: rdata=%h rvalid0=%0b rvalid1=%0b, want all zero",
                 idx, rdata, rvalid0, rvalid1);
      end
    end

    if (v.g0) begin
      if (v.w0) shadow[v.a0] = v.d0;
      else      sb.push_back('{port: 1'b0, data: shadow[v.a0]});
    end else if (v.g1) begin
      if (v.w1) shadow[v.a1] = v.d1;
      else      sb.push_back('{port: 1'b1, data: shadow[v.a1]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; mem_load = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i[7:0]);
    @(posedge clk);
    #1 mem_load = 1'b0;

    //              n  r0 w0 l0 a0     d0            r1 w1 l1 a1     d1           g0 g1
    // reset held with both ports requesting
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 0, 8'h10, 32'h0,        1, 0, 0, 8'h20, 32'h0,        0, 0));
    // tie-break: alternate 0,1,0,1
    vecs.push_back(mk(1, 1, 0, 0, 8'h10, 32'h0,        1, 0, 0, 8'h20, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h10, 32'h0,        1, 0, 0, 8'h20, 32'h0,        0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 8'h10, 32'h0,        1, 0, 0, 8'h20, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h10, 32'h0,        1, 0, 0, 8'h20, 32'h0,        0, 1));
    // single requester, leaves last = 0 so port 1 wins the next tie
    vecs.push_back(mk(1, 1, 0, 0, 8'h31, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
    // port 1 locked write burst, port 0 held off
    vecs.push_back(mk(1, 1, 0, 0, 8'h30, 32'h0,        1, 1, 1, 8'h05, 32'hA5,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 8'h30, 32'h0,        1, 1, 1, 8'h05, 32'hA5,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 8'h30, 32'h0,        1, 1, 1, 8'h05, 32'hA5,       0, 1));
    // release cycle still belongs to port 1
    vecs.push_back(mk(1, 1, 0, 0, 8'h30, 32'h0,        1, 1, 0, 8'h06, 32'h5A,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 8'h30, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
    // lock from a losing port has no effect
    vecs.push_back(mk(1, 1, 0, 1, 8'h32, 32'h0,        1, 0, 0, 8'h33, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h34, 32'h0,        0, 1));
    // both locks on a tie: round-robin winner (port 0) takes the lock
    vecs.push_back(mk(1, 1, 0, 1, 8'h35, 32'h0,        1, 0, 1, 8'h36, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 8'h35, 32'h0,        1, 0, 1, 8'h36, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h35, 32'h0,        1, 0, 1, 8'h36, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h35, 32'h0,        1, 0, 0, 8'h36, 32'h0,        0, 1));
    // pipelined reads 0x00..0x03
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, 0, 0, i[7:0], 32'h0,     0, 0, 0, 8'h00, 32'h0,        1, 0));
    // write then read the same address
    vecs.push_back(mk(1, 1, 1, 0, 8'h7F, 32'hDEADBEEF, 0, 0, 0, 8'h00, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h7F, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
    // reset mid-read (port 1 also locked): response dropped, state back to IDLE
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h0,        1, 0, 1, 8'h40, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 8'h41, 32'h0,        1, 0, 1, 8'h42, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h41, 32'h0,        1, 0, 0, 8'h42, 32'h0,        1, 0));
    // reset after a port 0 grant: last returns to 1 so port 0 wins the tie
    vecs.push_back(mk(1, 1, 0, 0, 8'h43, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h44, 32'h0,        1, 0, 0, 8'h45, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h44, 32'h0,        1, 0, 0, 8'h45, 32'h0,        1, 0));
    // read back the locked burst data
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h05, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h06, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Lock held with no request still blocks port 1, and so does the release cycle.
    step(mk(1, 1, 1, 1, 8'h50, 32'h11, 1, 0, 0, 8'h51, 32'h0, 1, 0), 100);
    step(mk(1, 0, 0, 1, 8'h00, 32'h0,  1, 0, 0, 8'h51, 32'h0, 0, 0), 101);
    step(mk(1, 0, 0, 0, 8'h00, 32'h0,  1, 0, 0, 8'h51, 32'h0, 0, 0), 102);
    step(mk(1, 0, 0, 0, 8'h00, 32'h0,  1, 0, 0, 8'h51, 32'h0, 0, 1), 103);
    step(mk(1, 0, 0, 0, 8'h00, 32'h0,  1, 0, 0, 8'h50, 32'h0, 0, 1), 104);
    step(mk(1, 0, 0, 0, 8'h00, 32'h0,  0, 0, 0, 8'h00, 32'h0, 0, 0), 105);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
